// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_pkg                                                     |
// | Brief  : Shared I2C master/responder state encoding and defaults.    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package i2c_pkg;

    localparam int c_clk_div_default = 4;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ADDR  = 4'd2,
        RW    = 4'd3,
        ACK1  = 4'd4,
        WRITE = 4'd5,
        READ  = 4'd6,
        ACK2  = 4'd7,
        STOP  = 4'd8
    } i2c_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_clk_gen                                                 |
// | Brief  : Quarter-bit tick generator; tick marks the last clk of each |
// |          quarter, quarter counts 0..3 within the bit period.          |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module i2c_clk_gen #(
    parameter int clk_div = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int c_cnt_w = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(clk_div - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_quarter;
    logic               w_wrap;

    assign w_wrap = (r_cnt == c_last);

    // Counters restart from zero whenever the bus goes idle so every
    // transaction begins on a clean quarter 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_quarter <= '0;
        end else if (!en) begin
            r_cnt     <= '0;
            r_quarter <= '0;
        end else if (w_wrap) begin
            r_cnt     <= '0;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt + c_cnt_w'(1);
        end
    end

    assign tick    = en && w_wrap;
    assign quarter = r_quarter;

endmodule
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : i2c_master                                                  |
// | Brief  : Single-byte I2C master (7-bit address, read or write).      |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module i2c_master
    import i2c_pkg::*;
#(
    parameter int data_wd = 8,
    parameter int addr_wd = 7,
    parameter int clk_div = c_clk_div_default
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               rw,
    input  logic [addr_wd-1:0] addr,
    input  logic [data_wd-1:0] wdata,
    output logic               scl,
    inout  wire                sda,
    output logic [data_wd-1:0] rdata,
    output logic               busy,
    output logic               done,
    output logic               ack_err
);

    localparam int c_max_wd = (addr_wd > data_wd) ? addr_wd : data_wd;
    localparam int c_bit_w  = ($clog2(c_max_wd) > 0) ? $clog2(c_max_wd) : 1;
    localparam logic [c_bit_w-1:0] c_addr_last = c_bit_w'(addr_wd - 1);
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(data_wd - 1);

    i2c_state_t         r_state;
    i2c_state_t         w_state_nxt;
    logic               w_tick;
    logic [1:0]         w_quarter;
    logic               w_busy;
    logic               w_accept;
    logic               w_bit_end;
    logic               w_sample;
    logic               w_bit_last;
    logic               w_data_scl;
    logic               w_scl;
    logic               w_sda_low;
    logic               w_sda_in;
    logic               r_rw;
    logic [addr_wd-1:0] r_addr_sh;
    logic [data_wd-1:0] r_wr_sh;
    logic [data_wd-1:0] r_rd_sh;
    logic [data_wd-1:0] w_rd_shift;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [data_wd-1:0] r_rdata;
    logic               r_done;
    logic               r_ack_err;

    i2c_clk_gen #(
        .clk_div (clk_div)
    ) u_clk_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_busy),
        .tick    (w_tick),
        .quarter (w_quarter)
    );

    assign w_busy     = (r_state != IDLE);
    assign w_accept   = (r_state == IDLE) && req;
    assign w_bit_end  = w_tick && (w_quarter == 2'd3);
    assign w_sample   = w_tick && (w_quarter == 2'd2);
    assign w_bit_last = (r_state == ADDR) ? (r_bit_cnt == c_addr_last)
                                          : (r_bit_cnt == c_data_last);
    assign w_data_scl = (w_quarter == 2'd1) || (w_quarter == 2'd2);
    assign w_sda_in   = sda;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda_low   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) w_state_nxt = START;
            end
            START: begin
                // SDA falls in Q2 while SCL is still high, SCL drops in Q3.
                w_scl     = (w_quarter != 2'd3);
                w_sda_low = w_quarter[1];
                if (w_bit_end) w_state_nxt = ADDR;
            end
            ADDR: begin
                w_scl     = w_data_scl;
                w_sda_low = ~r_addr_sh[0];
                if (w_bit_end && w_bit_last) w_state_nxt = RW;
            end
            RW: begin
                w_scl     = w_data_scl;
                w_sda_low = ~r_rw;
                if (w_bit_end) w_state_nxt = ACK1;
            end
            ACK1: begin
                w_scl = w_data_scl;
                if (w_bit_end) begin
                    w_state_nxt = r_ack_err ? STOP : (r_rw ? READ : WRITE);
                end
            end
            WRITE: begin
                w_scl     = w_data_scl;
                w_sda_low = ~r_wr_sh[0];
                if (w_bit_end && w_bit_last) w_state_nxt = ACK2;
            end
            READ: begin
                w_scl = w_data_scl;
                if (w_bit_end && w_bit_last) w_state_nxt = ACK2;
            end
            ACK2: begin
                w_scl = w_data_scl;
                if (w_bit_end) w_state_nxt = STOP;
            end
            STOP: begin
                // SDA held low through the SCL rise, released once SCL is high.
                w_scl     = (w_quarter != 2'd0);
                w_sda_low = ~w_quarter[1];
                if (w_bit_end) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        w_rd_shift              = r_rd_sh >> 1;
        w_rd_shift[data_wd-1]   = w_sda_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw      <= 1'b0;
            r_addr_sh <= '0;
            r_wr_sh   <= '0;
            r_rd_sh   <= '0;
            r_bit_cnt <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= (r_state == STOP) && w_bit_end;
            if (w_accept) begin
                r_rw      <= rw;
                r_addr_sh <= addr;
                r_wr_sh   <= wdata;
                r_ack_err <= 1'b0;
                r_bit_cnt <= '0;
            end
            if (w_bit_end && ((r_state == ADDR) || (r_state == WRITE) || (r_state == READ))) begin
                r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + c_bit_w'(1);
            end
            if (w_bit_end && (r_state == ADDR)) r_addr_sh <= r_addr_sh >> 1;
            if (w_bit_end && (r_state == WRITE)) r_wr_sh <= r_wr_sh >> 1;
            if (w_sample && (r_state == READ)) r_rd_sh <= w_rd_shift;
            if (w_sample && w_sda_in &&
                ((r_state == ACK1) || ((r_state == ACK2) && !r_rw))) begin
                r_ack_err <= 1'b1;
            end
            if (w_bit_end && (r_state == ACK2) && r_rw) r_rdata <= r_rd_sh;
        end
    end

    assign sda     = w_sda_low ? 1'b0 : 1'bz;
    assign scl     = w_scl;
    assign busy    = w_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_i2c_master                                               |
// | Brief  : Bus-level checks of i2c_master at clk_div=4 and clk_div=1.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_i2c_master;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sel;
    logic       resp_low;

    wire        sda4;
    wire        sda1;
    logic       scl4, scl1, busy4, busy1, done4, done1, ack4, ack1;
    logic [7:0] rdata4, rdata1;

    wire        req4 = req & ~sel;
    wire        req1 = req & sel;

    i2c_master #(.data_wd(8), .addr_wd(7), .clk_div(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .rw(rw), .addr(addr), .wdata(wdata),
        .scl(scl4), .sda(sda4), .rdata(rdata4), .busy(busy4), .done(done4), .ack_err(ack4)
    );

    i2c_master #(.data_wd(8), .addr_wd(7), .clk_div(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .rw(rw), .addr(addr), .wdata(wdata),
        .scl(scl1), .sda(sda1), .rdata(rdata1), .busy(busy1), .done(done1), .ack_err(ack1)
    );

    pullup (sda4);
    pullup (sda1);
    assign sda4 = (resp_low && !sel) ? 1'b0 : 1'bz;
    assign sda1 = (resp_low && sel) ? 1'b0 : 1'bz;

    wire       m_scl  = sel ? scl1 : scl4;
    wire       m_sda  = sel ? sda1 : sda4;
    wire       m_busy = sel ? busy1 : busy4;
    wire       m_done = sel ? done1 : done4;
    wire       m_ack  = sel ? ack1 : ack4;
    wire [7:0] m_rd   = sel ? rdata1 : rdata4;

    always #5 clk = ~clk;

    // Expected per-cycle {scl, sda-on-bus} and responder pull-down schedule.
    logic [1:0] exp_q[$];
    logic       resp_q[$];
    logic       exp_ack;
    logic [7:0] m_rdata [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic add_bit(input int d, input logic [3:0] scl_q, input logic [3:0] sda_q,
                           input logic rl);
        for (int q = 0; q < 4; q++) begin
            for (int c = 0; c < d; c++) begin
                exp_q.push_back({scl_q[q], sda_q[q] & ~rl});
                resp_q.push_back(rl);
            end
        end
    endtask

    // mode: 0 = no responder, 1 = responder ACKs all, 2 = ACKs address, NACKs data
    task automatic build(input int d, input logic r, input logic [6:0] a, input logic [7:0] wd,
                         input int mode, input logic [7:0] rb);
        exp_q.delete();
        resp_q.delete();
        add_bit(d, 4'b0111, 4'b0011, 1'b0);
        for (int i = 0; i < 7; i++) add_bit(d, 4'b0110, {4{a[i]}}, 1'b0);
        add_bit(d, 4'b0110, {4{r}}, 1'b0);
        add_bit(d, 4'b0110, 4'b1111, mode != 0);
        if (mode != 0) begin
            for (int i = 0; i < 8; i++) begin
                if (r) add_bit(d, 4'b0110, 4'b1111, ~rb[i]);
                else   add_bit(d, 4'b0110, {4{wd[i]}}, 1'b0);
            end
            add_bit(d, 4'b0110, 4'b1111, !r && (mode == 1));
        end
        add_bit(d, 4'b1110, 4'b1100, 1'b0);
        exp_ack = (mode == 0) || (!r && (mode == 2));
        if ((mode != 0) && r) m_rdata[sel] = rb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("idle", {m_scl, m_sda, m_busy, m_done}, 4'b1100);
        end
    endtask

    task automatic run_txn(input logic s, input logic r, input logic [6:0] a, input logic [7:0] wd,
                           input int mode, input logic [7:0] rb, input int glitch_at,
                           input int reset_at, output int busy_cnt, output logic [19:0] obs);
        int d;
        int len;
        d   = s ? 1 : 4;
        sel = s;
        build(d, r, a, wd, mode, rb);
        len      = exp_q.size();
        busy_cnt = 0;
        obs      = '0;
        rw    = r;
        addr  = a;
        wdata = wd;
        req   = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            resp_low = resp_q[k];
            #1;
            if (m_busy) busy_cnt++;
            chk("bus", {m_scl, m_sda, m_busy, m_done}, {exp_q[k], 2'b10});
            if (k == 0) begin
                chk("ack_err_clear", m_ack, 0);
                req = 1'b0;
            end
            if (((k / d) % 4 == 2) && (k % d == d - 1)) obs[k / (4 * d)] = m_sda;
            if (k == glitch_at) begin
                req = 1'b1; rw = ~r; addr = ~a; wdata = ~wd;
            end
            if (k == glitch_at + 1) begin
                req = 1'b0; rw = r; addr = a; wdata = wd;
            end
            if (k == reset_at) begin
                rst_n    = 1'b0;
                resp_low = 1'b0;
                #1;
                chk("reset_now", {m_scl, m_sda, m_busy, m_done, m_ack}, 5'b11000);
                chk("reset_rdata", m_rd, 0);
                m_rdata[0] = 8'h00;
                m_rdata[1] = 8'h00;
                @(negedge clk);
                #1;
                chk("reset_no_done", {m_scl, m_sda, m_busy, m_done}, 4'b1100);
                rst_n = 1'b1;
                return;
            end
        end
        @(negedge clk);
        resp_low = 1'b0;
        #1;
        chk("end_state", {m_scl, m_sda, m_busy, m_done}, 4'b1101);
        chk("ack_err", m_ack, exp_ack);
        chk("rdata", m_rd, m_rdata[sel]);
    endtask

    initial begin
        int          bc;
        logic [19:0] ob;
        clk        = 1'b0;
        rst_n      = 1'b0;
        req        = 1'b0;
        rw         = 1'b0;
        addr       = '0;
        wdata      = '0;
        sel        = 1'b0;
        resp_low   = 1'b0;
        m_rdata[0] = 8'h00;
        m_rdata[1] = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_dut4", {scl4, sda4, busy4, done4, ack4}, 5'b11000);
        chk("rst_rdata4", rdata4, 0);
        chk("rst_dut1", {scl1, sda1, busy1, done1, ack1}, 5'b11000);
        chk("rst_rdata1", rdata1, 0);
        rst_n = 1'b1;
        idle(2);

        // Write 0x2A/0x5A with a stray req mid-address, then a back-to-back read.
        run_txn(1'b0, 1'b0, 7'h2A, 8'h5A, 1, 8'h00, 40, -10, bc, ob);
        chk("t1_busy_cycles", bc, 320);
        chk("t1_addr_rw_bits", ob[8:1], 8'h2A);
        chk("t1_data_bits", ob[17:10], 8'h5A);
        run_txn(1'b0, 1'b1, 7'h15, 8'h00, 1, 8'hC3, -10, -10, bc, ob);
        chk("t2_busy_cycles", bc, 320);
        chk("t2_rdata", rdata4, 8'hC3);
        chk("t2_master_nack", ob[18], 1);
        idle(3);

        // No responder: address NACK aborts to STOP.
        run_txn(1'b0, 1'b0, 7'h33, 8'hA5, 0, 8'h00, -10, -10, bc, ob);
        chk("t3_busy_cycles", bc, 176);
        chk("t3_ack_err", ack4, 1);
        chk("t3_nack_on_bus", ob[9], 1);
        idle(2);

        // Reset in the middle of WRITE bit 3.
        run_txn(1'b0, 1'b0, 7'h2A, 8'h5A, 1, 8'h00, -10, 13 * 16 + 8, bc, ob);
        idle(2);

        // Responder NACKs the data byte.
        run_txn(1'b0, 1'b0, 7'h11, 8'h3C, 2, 8'h00, -10, -10, bc, ob);
        chk("t5_busy_cycles", bc, 320);
        chk("t5_data_nack", ack4, 1);
        idle(2);

        // Fastest divider: write 0xFF.
        run_txn(1'b1, 1'b0, 7'h55, 8'hFF, 1, 8'h00, -10, -10, bc, ob);
        chk("t6_busy_cycles", bc, 80);
        chk("t6_addr_rw_bits", ob[8:1], 8'h55);
        chk("t6_data_bits", ob[17:10], 8'hFF);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter data_wd, default 8, data byte width.
REQ-002 SHALL have parameter addr_wd, default 7, responder address width.
REQ-003 SHALL have parameter clk_div, default 4, clk cycles per SCL quarter-period (minimum 1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  transaction request.
REQ-007 SHALL have port rw  input  1  transaction direction (1 = read, 0 = write).
REQ-008 SHALL have port addr  input  addr_wd  target address.
REQ-009 SHALL have port wdata  input  data_wd  write byte.
REQ-010 SHALL have port scl  output  1  I2C clock (push-pull).
REQ-011 SHALL have port sda  inout  1  I2C data (open-drain: drives 0 or z).
REQ-012 SHALL have port rdata  output  data_wd  last read byte.
REQ-013 SHALL have port busy  output  1  transaction in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port ack_err  output  1  responder NACK seen in the last transaction.

Function
REQ-016 SHALL accept req only when busy=0; on acceptance, capture rw, addr and wdata, and assert busy the next cycle.
REQ-017 SHALL ignore req while busy=1; captured values SHALL NOT change mid-transaction.
REQ-018 SHALL use the FSM states IDLE, START, ADDR, RW, ACK1, WRITE, READ, ACK2, STOP.
REQ-019 SHALL divide each bit period into 4 quarters of clk_div cycles: Q0 SCL low with SDA updated, Q1 SCL rising, Q2 SCL high with SDA sampled, Q3 SCL falling.
REQ-020 SHALL, in START, pull SDA low while SCL=1, then drive SCL low (one bit period).
REQ-021 SHALL, in ADDR, send addr LSB first, bit index 0..addr_wd-1, one bit per bit period.
REQ-022 SHALL, in RW, send the rw bit.
REQ-023 SHALL, in ACK1, release SDA and sample it at Q2; SDA=1 sets ack_err=1 and goes to STOP.
REQ-024 SHALL, in WRITE, send wdata LSB first, data_wd bits; ACK2 then samples the responder ACK (SDA=1 sets ack_err=1).
REQ-025 SHALL, in READ, release SDA and shift in data_wd bits LSB first; ACK2 then releases SDA (master NACK), and rdata updates at the end of ACK2.
REQ-026 SHALL, in STOP, hold SDA low with SCL rising, then release SDA while SCL=1, then return to IDLE.
REQ-027 SHALL, on a full transaction, hold busy for exactly 80*clk_div cycles (20 bit periods).
REQ-028 SHALL, on an ACK1 NACK abort, hold busy for exactly 44*clk_div cycles (11 bit periods).
REQ-029 SHALL pulse done for exactly one cycle: the first cycle busy=0 after a transaction.
REQ-030 SHALL clear ack_err on acceptance of a new req.
REQ-031 SHALL, in IDLE, hold scl=1 with SDA released.
REQ-032 SHALL, when req is asserted in the cycle done pulses, accept it (back-to-back transactions).

Reset
REQ-033 SHALL, while rst_n=0, immediately drive scl=1, release SDA, and set busy=0, done=0, ack_err=0, rdata=0, FSM=IDLE, and all counters to 0.
REQ-034 SHALL abort any in-flight transaction on reset mid-operation, with no STOP generated and no done pulse.

Structure
REQ-035 SHALL place the FSM state enum and the default clk_div constant in shared package i2c_pkg, also usable by the responder.
REQ-036 SHALL implement quarter-phase tick generation in sub-module i2c_clk_gen, which outputs a tick and a 2-bit quarter index.

Verification
REQ-037 SHALL cover: write addr=0x2A, wdata=0x5A, responder ACKs -> SDA shows 0,1,0,1,0,1,0,0 then 0,1,0,1,1,0,1,0 LSB-first, ack_err=0, done after 80*clk_div cycles.
REQ-038 SHALL cover: read addr=0x15, responder drives 0xC3 -> rdata=0xC3, master NACK at ACK2, ack_err=0.
REQ-039 SHALL cover: no responder (SDA pulled high) -> ack_err=1, STOP issued, busy high for 44*clk_div cycles, done pulses.
REQ-040 SHALL cover: req pulsed mid-transaction with different addr -> ignored, bus sequence unchanged; req held at done -> second transaction starts immediately.
REQ-041 SHALL cover: rst_n low during the WRITE bit 3 -> scl=1, SDA=z and busy=0 in the same cycle, no done pulse.
REQ-042 SHALL cover: clk_div=1 write of 0xFF -> correct timing, done after 80 cycles.
